// File: rtl/operand_fetch_stage_if.sv
// Instruction-in / operands-out handshake bundle of the operand fetch stage.
// slave: the stage's view; master: the decode/execute environment's view.
interface operand_fetch_stage_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = 16
);
  localparam int unsigned REG_W = 5;

  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_pc;
  logic [REG_W-1:0]  in_rs1;
  logic [REG_W-1:0]  in_rs2;
  logic              in_use_rs1;
  logic              in_use_rs2;
  logic [REG_W-1:0]  in_rd;
  logic [XLEN-1:0]   in_imm;
  logic [CTRL_W-1:0] in_ctrl;

  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [XLEN-1:0]   out_imm;
  logic [XLEN-1:0]   out_rs1_val;
  logic [XLEN-1:0]   out_rs2_val;
  logic [REG_W-1:0]  out_rd;
  logic [CTRL_W-1:0] out_ctrl;

  modport slave (
    input  in_valid, in_pc, in_rs1, in_rs2, in_use_rs1, in_use_rs2, in_rd, in_imm, in_ctrl,
    output in_ready,
    output out_valid, out_pc, out_imm, out_rs1_val, out_rs2_val, out_rd, out_ctrl,
    input  out_ready
  );

  modport master (
    output in_valid, in_pc, in_rs1, in_rs2, in_use_rs1, in_use_rs2, in_rd, in_imm, in_ctrl,
    input  in_ready,
    input  out_valid, out_pc, out_imm, out_rs1_val, out_rs2_val, out_rd, out_ctrl,
    output out_ready
  );
endinterface

// File: rtl/operand_fetch_stage.sv
// Decode-to-execute operand fetch: RF read, EX/WB bypass, hazard stall, ID/EX register.
// Define OF_BYPASS_EN to enable EX/WB forwarding (load-use stalls only); otherwise any RAW stalls.
module operand_fetch_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  operand_fetch_stage_if.slave bus,
  output logic [4:0]           rf_rd_addr1,
  output logic [4:0]           rf_rd_addr2,
  input  logic [XLEN-1:0]      rf_rd_data1,
  input  logic [XLEN-1:0]      rf_rd_data2,
  input  logic                 ex_valid,
  input  logic [4:0]           ex_rd,
  input  logic                 ex_is_load,
  input  logic [XLEN-1:0]      ex_result,
  input  logic                 wb_we,
  input  logic [4:0]           wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 flush,
  output logic [15:0]          stall_cycles
);

  localparam int unsigned REG_W   = 5;
  localparam int unsigned STALL_W = 16;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [REG_W-1:0]  rd;
    logic [CTRL_W-1:0] ctrl;
  } idex_t;

  idex_t               payload_q, payload_d;
  logic                valid_q, valid_d;
  logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic [XLEN-1:0]     rs1_val_c, rs2_val_c;
  logic                stall_c;
  logic                ready_c;
  logic                accept_c;

  assign rf_rd_addr1 = bus.in_rs1;
  assign rf_rd_addr2 = bus.in_rs2;

  // Later assignments win: x0 beats EX, EX beats WB, WB beats the register file.
  always_comb begin : resolve
    rs1_val_c = rf_rd_data1;
    rs2_val_c = rf_rd_data2;
`ifdef OF_BYPASS_EN
    if (wb_we && (wb_rd == bus.in_rs1)) rs1_val_c = wb_data;
    if (wb_we && (wb_rd == bus.in_rs2)) rs2_val_c = wb_data;
    if (ex_valid && !ex_is_load && (ex_rd == bus.in_rs1)) rs1_val_c = ex_result;
    if (ex_valid && !ex_is_load && (ex_rd == bus.in_rs2)) rs2_val_c = ex_result;
`endif
    if (bus.in_rs1 == '0) rs1_val_c = '0;
    if (bus.in_rs2 == '0) rs2_val_c = '0;
  end

`ifdef OF_BYPASS_EN
  // Only a load in EX cannot be forwarded yet.
  assign stall_c = bus.in_valid && ex_valid && ex_is_load && (ex_rd != '0) &&
                   ((bus.in_use_rs1 && (ex_rd == bus.in_rs1)) ||
                    (bus.in_use_rs2 && (ex_rd == bus.in_rs2)));
`else
  logic busy1_c, busy2_c;
  logic unused_bypass_c;

  // Without forwarding, wait until neither EX nor WB still owes the source.
  assign busy1_c = bus.in_use_rs1 && (bus.in_rs1 != '0) &&
                   ((ex_valid && (ex_rd == bus.in_rs1)) || (wb_we && (wb_rd == bus.in_rs1)));
  assign busy2_c = bus.in_use_rs2 && (bus.in_rs2 != '0) &&
                   ((ex_valid && (ex_rd == bus.in_rs2)) || (wb_we && (wb_rd == bus.in_rs2)));
  assign stall_c = bus.in_valid && (busy1_c || busy2_c);
  assign unused_bypass_c = ^{ex_is_load, ex_result, wb_data};
`endif

  assign ready_c      = !flush && !stall_c && (!valid_q || bus.out_ready);
  assign accept_c     = bus.in_valid && ready_c;
  assign bus.in_ready = ready_c;

  // ID/EX register update: flush kills, accept loads, drained slot empties, else hold.
  always_comb begin : next_state
    valid_d     = valid_q;
    payload_d   = payload_q;
    stall_cnt_d = stall_cnt_q;

    if (flush) begin
      valid_d = 1'b0;
    end else if (accept_c) begin
      valid_d           = 1'b1;
      payload_d.pc      = bus.in_pc;
      payload_d.imm     = bus.in_imm;
      payload_d.rs1_val = rs1_val_c;
      payload_d.rs2_val = rs2_val_c;
      payload_d.rd      = bus.in_rd;
      payload_d.ctrl    = bus.in_ctrl;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end

    if (stall_c && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin : state_reg
    if (!rst) begin
      valid_q     <= 1'b0;
      payload_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      payload_q   <= payload_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.out_pc      = payload_q.pc;
  assign bus.out_imm     = payload_q.imm;
  assign bus.out_rs1_val = payload_q.rs1_val;
  assign bus.out_rs2_val = payload_q.rs2_val;
  assign bus.out_rd      = payload_q.rd;
  assign bus.out_ctrl    = payload_q.ctrl;
  assign stall_cycles    = stall_cnt_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage: directed cases plus randomized traffic
// against a behavioural model (register-file array + "newest value" rule).
module tb_operand_fetch_stage;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned CTRL_W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  operand_fetch_stage_if #(.XLEN(XLEN), .CTRL_W(CTRL_W)) bus ();

  logic [4:0]      rf_rd_addr1, rf_rd_addr2;
  logic [XLEN-1:0] rf_rd_data1, rf_rd_data2;
  logic            ex_valid, ex_is_load, wb_we, flush;
  logic [4:0]      ex_rd, wb_rd;
  logic [XLEN-1:0] ex_result, wb_data;
  logic [15:0]     stall_cycles;

  operand_fetch_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .rf_rd_addr1  (rf_rd_addr1),
    .rf_rd_addr2  (rf_rd_addr2),
    .rf_rd_data1  (rf_rd_data1),
    .rf_rd_data2  (rf_rd_data2),
    .ex_valid     (ex_valid),
    .ex_rd        (ex_rd),
    .ex_is_load   (ex_is_load),
    .ex_result    (ex_result),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .flush        (flush),
    .stall_cycles (stall_cycles)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: architectural register file plus the expected ID/EX contents.
  logic [XLEN-1:0]   regs [32];
  bit                m_valid;
  logic [XLEN-1:0]   m_pc, m_imm, m_rs1v, m_rs2v;
  logic [4:0]        m_rd;
  logic [CTRL_W-1:0] m_ctrl;
  int                m_stalls;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit src_busy(input logic use_it, input logic [4:0] idx);
    return use_it && (idx != 5'd0) &&
           ((ex_valid && ex_rd == idx) || (wb_we && wb_rd == idx));
  endfunction

  function automatic bit hazard();
`ifdef OF_BYPASS_EN
    return bus.in_valid && ex_valid && ex_is_load && (ex_rd != 5'd0) &&
           ((bus.in_use_rs1 && ex_rd == bus.in_rs1) || (bus.in_use_rs2 && ex_rd == bus.in_rs2));
`else
    return bus.in_valid && (src_busy(bus.in_use_rs1, bus.in_rs1) || src_busy(bus.in_use_rs2, bus.in_rs2));
`endif
  endfunction

  // Value the instruction must observe for a source index this cycle.
  function automatic logic [XLEN-1:0] newest(input logic [4:0] idx);
    if (idx == 5'd0) return '0;
`ifdef OF_BYPASS_EN
    if (ex_valid && !ex_is_load && ex_rd == idx) return ex_result;
    if (wb_we && wb_rd == idx) return wb_data;
`endif
    return regs[idx];
  endfunction

  task automatic set_idle();
    bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
    bus.in_use_rs1 = 1'b0; bus.in_use_rs2 = 1'b0; bus.in_rd = '0; bus.in_imm = '0;
    bus.in_ctrl = '0; bus.out_ready = 1'b1;
    ex_valid = 1'b0; ex_rd = '0; ex_is_load = 1'b0; ex_result = '0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b0;
    #2;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_stall_cycles", 64'(stall_cycles), 64'd0);
    chk("rst_out_pc", 64'(bus.out_pc), 64'd0);
    chk("rst_out_imm", 64'(bus.out_imm), 64'd0);
    chk("rst_out_rs1_val", 64'(bus.out_rs1_val), 64'd0);
    chk("rst_out_rs2_val", 64'(bus.out_rs2_val), 64'd0);
    chk("rst_out_rd", 64'(bus.out_rd), 64'd0);
    chk("rst_out_ctrl", 64'(bus.out_ctrl), 64'd0);
    m_valid = 1'b0;
    m_stalls = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("in_ready_after_reset", 64'(bus.in_ready), 64'd1);
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic step(output bit ready_seen);
    bit st, rdy, acc;
    rf_rd_data1 = regs[bus.in_rs1];
    rf_rd_data2 = regs[bus.in_rs2];
    #1;
    st  = hazard();
    rdy = !flush && !st && (!m_valid || bus.out_ready);
    chk("in_ready", 64'(bus.in_ready), 64'(rdy));
    chk("rf_rd_addr1", 64'(rf_rd_addr1), 64'(bus.in_rs1));
    chk("rf_rd_addr2", 64'(rf_rd_addr2), 64'(bus.in_rs2));
    ready_seen = bus.in_ready;
    acc = bus.in_valid && rdy;
    if (flush) begin
      m_valid = 1'b0;
    end else if (acc) begin
      m_valid = 1'b1;
      m_pc    = bus.in_pc;
      m_imm   = bus.in_imm;
      m_rd    = bus.in_rd;
      m_ctrl  = bus.in_ctrl;
      m_rs1v  = newest(bus.in_rs1);
      m_rs2v  = newest(bus.in_rs2);
    end else if (bus.out_ready) begin
      m_valid = 1'b0;
    end
    if (st && m_stalls < 65535) m_stalls++;
    if (wb_we && wb_rd != 5'd0) regs[wb_rd] = wb_data;
    @(posedge clk);
    #1;
    chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
    chk("stall_cycles", 64'(stall_cycles), 64'(m_stalls));
    if (m_valid) begin
      chk("out_pc", 64'(bus.out_pc), 64'(m_pc));
      chk("out_imm", 64'(bus.out_imm), 64'(m_imm));
      chk("out_rs1_val", 64'(bus.out_rs1_val), 64'(m_rs1v));
      chk("out_rs2_val", 64'(bus.out_rs2_val), 64'(m_rs2v));
      chk("out_rd", 64'(bus.out_rd), 64'(m_rd));
      chk("out_ctrl", 64'(bus.out_ctrl), 64'(m_ctrl));
    end
  endtask

  task automatic rand_inputs();
    bus.in_valid   = 1'($urandom_range(0, 3) != 0);
    bus.in_pc      = $urandom;
    bus.in_rs1     = 5'($urandom_range(0, 7));
    bus.in_rs2     = 5'($urandom_range(0, 7));
    bus.in_use_rs1 = 1'($urandom_range(0, 1));
    bus.in_use_rs2 = 1'($urandom_range(0, 1));
    bus.in_rd      = 5'($urandom_range(0, 31));
    bus.in_imm     = $urandom;
    bus.in_ctrl    = CTRL_W'($urandom);
    bus.out_ready  = 1'($urandom_range(0, 3) != 0);
    ex_valid       = 1'($urandom_range(0, 1));
    ex_rd          = 5'($urandom_range(0, 7));
    ex_is_load     = 1'($urandom_range(0, 2) == 0);
    ex_result      = $urandom;
    wb_we          = 1'($urandom_range(0, 1));
    wb_rd          = 5'($urandom_range(0, 7));
    wb_data        = $urandom;
    flush          = 1'($urandom_range(0, 15) == 0);
  endtask

  initial begin
    bit r;
    for (int i = 0; i < 32; i++) regs[i] = '0;
    m_pc = '0; m_imm = '0; m_rs1v = '0; m_rs2v = '0; m_rd = '0; m_ctrl = '0;
    rf_rd_data1 = '0; rf_rd_data2 = '0;
    set_idle();
    rst = 1'b1;
    #1;
    do_reset();

    // Single instruction, one-cycle latency.
    regs[3] = 32'h11; regs[4] = 32'h22;
    bus.in_valid = 1'b1; bus.in_pc = 32'h40; bus.in_rs1 = 5'd3; bus.in_rs2 = 5'd4;
    bus.in_use_rs1 = 1'b1; bus.in_use_rs2 = 1'b1; bus.in_rd = 5'd1;
    step(r);
    chk("t1_in_ready", 64'(r), 64'd1);
    chk("t1_out_valid", 64'(bus.out_valid), 64'd1);
    chk("t1_rs1_val", 64'(bus.out_rs1_val), 64'h11);
    chk("t1_rs2_val", 64'(bus.out_rs2_val), 64'h22);

    // Backpressure holds the payload stable.
    bus.out_ready = 1'b0; bus.in_pc = 32'h80;
    repeat (3) begin
      step(r);
      chk("bp_in_ready", 64'(r), 64'd0);
      chk("bp_out_pc_held", 64'(bus.out_pc), 64'h40);
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
    end
    bus.out_ready = 1'b1;
    step(r);
    chk("bp_release_ready", 64'(r), 64'd1);
    chk("bp_release_pc", 64'(bus.out_pc), 64'h80);

    // Flush kills the incoming instruction and empties the slot.
    flush = 1'b1; bus.in_pc = 32'hC0;
    step(r);
    chk("flush_in_ready", 64'(r), 64'd0);
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    flush = 1'b0; bus.in_valid = 1'b0;
    step(r);
    chk("flush_no_capture", 64'(bus.out_valid), 64'd0);

`ifdef OF_BYPASS_EN
    // EX wins over WB; x0 reads zero.
    do_reset();
    regs[5] = 32'h1234;
    ex_valid = 1'b1; ex_rd = 5'd5; ex_result = 32'hAAAA; ex_is_load = 1'b0;
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hBBBB;
    bus.in_valid = 1'b1; bus.in_rs1 = 5'd5; bus.in_rs2 = 5'd0;
    bus.in_use_rs1 = 1'b1; bus.in_use_rs2 = 1'b1;
    step(r);
    chk("exbp_rs1_val", 64'(bus.out_rs1_val), 64'hAAAA);
    chk("exbp_rs2_val", 64'(bus.out_rs2_val), 64'd0);

    // Load-use: one bubble, then WB forwards the load data.
    ex_is_load = 1'b1; ex_rd = 5'd7; wb_we = 1'b0;
    bus.in_rs1 = 5'd0; bus.in_rs2 = 5'd7; bus.in_use_rs2 = 1'b1;
    step(r);
    chk("lu_in_ready", 64'(r), 64'd0);
    chk("lu_bubble", 64'(bus.out_valid), 64'd0);
    chk("lu_stall_cycles", 64'(stall_cycles), 64'd1);
    ex_valid = 1'b0; wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'h55;
    step(r);
    chk("lu_release_ready", 64'(r), 64'd1);
    chk("lu_out_valid", 64'(bus.out_valid), 64'd1);
    chk("lu_rs2_val", 64'(bus.out_rs2_val), 64'h55);
`else
    // No forwarding: stall while WB owes x9, then read the written value.
    do_reset();
    wb_we = 1'b1; wb_rd = 5'd9; wb_data = 32'h99;
    bus.in_valid = 1'b1; bus.in_rs1 = 5'd9; bus.in_use_rs1 = 1'b1;
    step(r);
    chk("nobp_stall_ready", 64'(r), 64'd0);
    chk("nobp_stall_cycles", 64'(stall_cycles), 64'd1);
    wb_we = 1'b0;
    step(r);
    chk("nobp_release_ready", 64'(r), 64'd1);
    chk("nobp_rs1_val", 64'(bus.out_rs1_val), 64'h99);
`endif

    // Stall counter saturation (a load hazard stalls in both builds).
    do_reset();
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd1;
    bus.in_valid = 1'b1; bus.in_rs1 = 5'd1; bus.in_use_rs1 = 1'b1;
    step(r);
    repeat (65533) @(posedge clk);
    m_stalls += 65533;
    #1;
    step(r);
    chk("sat_reach", 64'(stall_cycles), 64'hFFFF);
    step(r);
    chk("sat_hold", 64'(stall_cycles), 64'hFFFF);

    // Randomized traffic, with one reset dropped in mid-stream.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      rand_inputs();
      step(r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Decode-to-execute operand fetch stage wrapped around the general-purpose register file.
- Accepts decoded instructions over a valid/ready handshake and drives the register file read addresses combinationally.
- Resolves RAW hazards by bypassing from the EX and WB stages, and inserts load-use stalls.
- Registers the resolved operands into the ID/EX pipeline register consumed by the execute stage.

Parameters:
- XLEN, 32, datapath/operand width.
- CTRL_W, 16, width of the opaque decoded control bundle passed through to EX.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  decoded instruction valid.
- in_ready  out  1  stage accepts instruction this cycle.
- in_pc  in  XLEN  instruction PC.
- in_rs1, in_rs2  in  5  source register indices.
- in_use_rs1, in_use_rs2  in  1  instruction actually reads rs1/rs2.
- in_rd  in  5  destination index.
- in_imm  in  XLEN  decoded immediate.
- in_ctrl  in  CTRL_W  control bundle.
- rf_rd_addr1, rf_rd_addr2  out  5  register file read addresses.
- rf_rd_data1, rf_rd_data2  in  XLEN  register file read data (x0 reads 0).
- ex_valid  in  1  EX stage holds a valid writing instruction.
- ex_rd  in  5  EX destination.
- ex_is_load  in  1  EX instruction is a load (result not yet available).
- ex_result  in  XLEN  EX ALU result.
- wb_we  in  1  WB write enable (same signal as the register file write enable).
- wb_rd  in  5  WB write address.
- wb_data  in  XLEN  WB write data.
- flush  in  1  kill the held and incoming instruction (branch redirect).
- out_valid  out  1  ID/EX register valid.
- out_ready  in  1  EX accepts.
- out_pc, out_imm  out  XLEN  registered PC and immediate.
- out_rs1_val, out_rs2_val  out  XLEN  resolved operands.
- out_rd  out  5  registered destination.
- out_ctrl  out  CTRL_W  registered control bundle.
- stall_cycles  out  16  saturating count of load-use stall cycles.

Behaviour:
- rf_rd_addr1/2 = in_rs1/in_rs2, purely combinational; register file read data returns in the same cycle.
- Operand resolution per source, highest priority first:
  1. Index 0 gives 0.
  2. ex_valid && !ex_is_load && ex_rd == idx gives ex_result.
  3. wb_we && wb_rd == idx gives wb_data. This path is required because the register file write lands only at the clock edge.
  4. Otherwise rf_rd_data.
- load_use = in_valid && ex_valid && ex_is_load && ex_rd != 0 && ((in_use_rs1 && ex_rd == in_rs1) || (in_use_rs2 && ex_rd == in_rs2)).
- in_ready = !flush && !load_use && (!out_valid || out_ready).
- Capture on in_valid && in_ready:
  - All out_* fields load the resolved values.
  - out_valid <= 1 at the next edge; latency is 1 cycle.
- No capture and out_ready == 1: out_valid <= 0, which creates a bubble during a load-use stall.
- No capture and out_ready == 0: hold all out_* fields stable; the held payload never changes while out_valid && !out_ready.
- flush has priority over everything: out_valid <= 0 next edge and no capture that cycle. Payload registers may hold stale data.
- stall_cycles increments each cycle load_use is 1 and saturates at 16'hFFFF.
- Reset (rst == 0, asynchronous):
  - out_valid = 0, stall_cycles = 0.
  - out_pc, out_imm, out_rs1_val, out_rs2_val, out_rd, out_ctrl = 0.
  - in_ready is combinational and reads 1 once rst deasserts, unless flush or load_use is active.
  - Reset mid-transfer drops the held instruction.
- Stall release: on the cycle after the load reaches WB, the WB bypass supplies the load data.

Optional Feature:
- OF_BYPASS_EN defined:
  - Operand resolution is as above.
  - Only load-use stalls.
- OF_BYPASS_EN undefined:
  - No EX/WB bypass; operands come from the register file or 0.
  - Stall condition widens to any used nonzero source matching ex_rd (ex_valid) or wb_rd (wb_we), regardless of ex_is_load.
  - stall_cycles counts all such stall cycles.

Test Plan:
- Reset then a single instruction: rst low, then rs1=3, rs2=4, rf data 0x11/0x22, out_ready=1 -> out_valid=1 one cycle after accept, out_rs1_val=0x11, out_rs2_val=0x22.
- EX bypass: ex_valid=1, ex_rd=5, ex_result=0xAAAA, wb_we=1, wb_rd=5, wb_data=0xBBBB, in_rs1=5 -> out_rs1_val=0xAAAA. Repeat with in_rs2=0 -> out_rs2_val=0.
- Load-use: ex_is_load=1, ex_rd=7, in_rs2=7, in_use_rs2=1 -> in_ready=0 for 1 cycle, out_valid=0 bubble, stall_cycles=1. Next cycle wb_rd=7, wb_data=0x55 -> accepted with out_rs2_val=0x55.
- Backpressure: out_ready=0 for 3 cycles with new in_valid -> in_ready=0, out_* stable. out_ready=1 -> next instruction captured.
- Flush: flush=1 with in_valid=1 and out_valid=1 -> in_ready=0, out_valid=0 next cycle, instruction not captured.
- Without OF_BYPASS_EN: wb_we=1, wb_rd=9, in_rs1=9 -> one-cycle stall, then out_rs1_val equals the register file value written.
